multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_pkg.sv | 126 ++++++++++++
 rtl/multicycle_control_aludec.sv | 39 +++
 rtl/multicycle_control.sv | 99 +++++++++
 tb/tb_multicycle_control.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_pkg
// Description : Shared definitions for the multicycle MIPS control unit:
//               FSM state encodings, opcode/funct constants, aluop and
//               alucontrol codes, the per-state control word and the
//               function that maps a state to its control word.
// Revision    : 1.0 - initial release
// ============================================================================
package multicycle_control_pkg;

    // FSM state encodings (4 bits; codes 12-15 are unused and recover to FETCH)
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    // Opcode field values
    localparam logic [5:0] C_OP_RTYPE = 6'b000000;
    localparam logic [5:0] C_OP_LW    = 6'b100011;
    localparam logic [5:0] C_OP_SW    = 6'b101011;
    localparam logic [5:0] C_OP_BEQ   = 6'b000100;
    localparam logic [5:0] C_OP_ADDI  = 6'b001000;
    localparam logic [5:0] C_OP_J     = 6'b000010;

    // R-type funct field values
    localparam logic [5:0] C_FN_ADD = 6'b100000;
    localparam logic [5:0] C_FN_SUB = 6'b100010;
    localparam logic [5:0] C_FN_AND = 6'b100100;
    localparam logic [5:0] C_FN_OR  = 6'b100101;
    localparam logic [5:0] C_FN_SLT = 6'b101010;

    // aluop codes (FSM -> ALU decoder)
    localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] C_ALUOP_FUNCT = 2'b10;

    // alucontrol codes (ALU decoder -> ALU)
    localparam logic [2:0] C_ALU_AND = 3'b000;
    localparam logic [2:0] C_ALU_OR  = 3'b001;
    localparam logic [2:0] C_ALU_ADD = 3'b010;
    localparam logic [2:0] C_ALU_SUB = 3'b110;
    localparam logic [2:0] C_ALU_SLT = 3'b111;

    // Control word produced by the FSM for each state
    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       iord;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
    } ctrl_t;

    // Control word for a state; everything not named for a state is 0.
    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.alusrcb = 2'b01;
                c.irwrite = 1'b1;
                c.pcwrite = 1'b1;
            end
            S_DECODE: begin
                c.alusrcb = 2'b11;
            end
            S_MEMADR, S_ADDIEXEC: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            S_MEMRD: begin
                c.iord = 1'b1;
            end
            S_MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            S_MEMWR: begin
                c.iord     = 1'b1;
                c.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                c.alusrca = 1'b1;
                c.aluop   = C_ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            S_ADDIWB: begin
                c.regwrite = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca = 1'b1;
                c.aluop   = C_ALUOP_SUB;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            S_JUMP: begin
                c.pcsrc   = 2'b10;
                c.pcwrite = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage : multicycle_control_pkg
`default_nettype wire

// File: rtl/multicycle_control_aludec.sv
`default_nettype none
// ============================================================================
// Module      : aludec
// Description : ALU decoder. Maps the FSM aluop and the instruction funct
//               field to the 3-bit ALU operation code.
// Ports       : funct      [5:0] in  - instruction funct field
//               aluop      [1:0] in  - operation class from the FSM
//               alucontrol [2:0] out - ALU operation code
// Revision    : 1.0 - initial release
// ============================================================================
module aludec
    import multicycle_control_pkg::*;
(
    input  logic [5:0] funct,
    input  logic [1:0] aluop,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = C_ALU_ADD;
        case (aluop)
            C_ALUOP_ADD: alucontrol = C_ALU_ADD;
            C_ALUOP_SUB: alucontrol = C_ALU_SUB;
            default: begin
                // aluop 10 and 11 both defer to funct; unknown funct adds
                case (funct)
                    C_FN_ADD: alucontrol = C_ALU_ADD;
                    C_FN_SUB: alucontrol = C_ALU_SUB;
                    C_FN_AND: alucontrol = C_ALU_AND;
                    C_FN_OR:  alucontrol = C_ALU_OR;
                    C_FN_SLT: alucontrol = C_ALU_SLT;
                    default:  alucontrol = C_ALU_ADD;
                endcase
            end
        endcase
    end

endmodule : aludec
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Control unit for a multicycle MIPS datapath. A Moore FSM
//               sequences each instruction; the control word is registered
//               alongside the state so every output is a function of the
//               current state only (plus zero for the branch PC enable).
// Ports       : clk                in  - clock, rising edge
//               reset              in  - asynchronous active-high reset
//               op[5:0], funct[5:0] in - instruction fields
//               zero               in  - ALU zero flag
//               pcen, memwrite, irwrite, regwrite, iord, regdst, memtoreg,
//               alusrca            out - datapath enables / selects
//               alusrcb[1:0], pcsrc[1:0], alucontrol[2:0] out - selects
//               state[3:0]         out - current FSM state
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    state_t r_state;
    ctrl_t  r_ctrl;
    state_t w_next;

    // Next-state logic
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH: w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    C_OP_LW, C_OP_SW: w_next = S_MEMADR;
                    C_OP_RTYPE:       w_next = S_EXECUTE;
                    C_OP_BEQ:         w_next = S_BRANCH;
                    C_OP_ADDI:        w_next = S_ADDIEXEC;
                    C_OP_J:           w_next = S_JUMP;
                    default:          w_next = S_FETCH;
                endcase
            end
            S_MEMADR:   w_next = (op == C_OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    w_next = S_MEMWB;
            S_EXECUTE:  w_next = S_ALUWB;
            S_ADDIEXEC: w_next = S_ADDIWB;
            default:    w_next = S_FETCH;
        endcase
    end

    // State and control word are registered together; reset loads the
    // FETCH control word so outputs show FETCH values while reset is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_ctrl  <= state_ctrl(S_FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= state_ctrl(w_next);
        end
    end

    aludec u_aludec (
        .funct      (funct),
        .aluop      (r_ctrl.aluop),
        .alucontrol (alucontrol)
    );

    // Branch is only ever set in BRANCH, so zero cannot reach pcen elsewhere
    assign pcen     = r_ctrl.pcwrite | (r_ctrl.branch & zero);
    assign memwrite = r_ctrl.memwrite;
    assign irwrite  = r_ctrl.irwrite;
    assign regwrite = r_ctrl.regwrite;
    assign iord     = r_ctrl.iord;
    assign regdst   = r_ctrl.regdst;
    assign memtoreg = r_ctrl.memtoreg;
    assign alusrca  = r_ctrl.alusrca;
    assign alusrcb  = r_ctrl.alusrcb;
    assign pcsrc    = r_ctrl.pcsrc;
    assign state    = r_state;

endmodule : multicycle_control
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Directed self-checking bench for multicycle_control. Each
//               instruction is stepped cycle by cycle and the state and the
//               packed output vector are compared against hand-computed
//               values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen, memwrite, irwrite, regwrite, iord, regdst, memtoreg, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_control u_dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pcen       (pcen),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .iord       (iord),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed outputs: {pcen,memwrite,irwrite,regwrite,iord,regdst,memtoreg,
    //                  alusrca, alusrcb[1:0], pcsrc[1:0], alucontrol[2:0]}
    logic [14:0] w_outs;
    assign w_outs = {pcen, memwrite, irwrite, regwrite, iord, regdst, memtoreg,
                     alusrca, alusrcb, pcsrc, alucontrol};

    localparam logic [14:0] V_FETCH  = {8'b1010_0000, 2'b01, 2'b00, 3'b010};
    localparam logic [14:0] V_DECODE = {8'b0000_0000, 2'b11, 2'b00, 3'b010};
    localparam logic [14:0] V_MEMADR = {8'b0000_0001, 2'b10, 2'b00, 3'b010};
    localparam logic [14:0] V_MEMRD  = {8'b0000_1000, 2'b00, 2'b00, 3'b010};
    localparam logic [14:0] V_MEMWB  = {8'b0001_0010, 2'b00, 2'b00, 3'b010};
    localparam logic [14:0] V_MEMWR  = {8'b0100_1000, 2'b00, 2'b00, 3'b010};
    localparam logic [14:0] V_ALUWB  = {8'b0001_0100, 2'b00, 2'b00, 3'b010};
    localparam logic [14:0] V_ADDIWB = {8'b0001_0000, 2'b00, 2'b00, 3'b010};
    localparam logic [14:0] V_BEQ_T  = {8'b1000_0001, 2'b00, 2'b01, 3'b110};
    localparam logic [14:0] V_BEQ_N  = {8'b0000_0001, 2'b00, 2'b01, 3'b110};
    localparam logic [14:0] V_JUMP   = {8'b1000_0000, 2'b00, 2'b10, 3'b010};

    // EXECUTE: alusrca=1, everything else 0 apart from the decoded ALU op
    function automatic logic [14:0] v_exec(input logic [2:0] alc);
        return {8'b0000_0001, 2'b00, 2'b00, alc};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Compare state and outputs at the falling edge, then advance one cycle
    task automatic step(input string tag, input logic [3:0] es, input logic [14:0] ev);
        check({tag, ".state"}, {28'd0, state}, {28'd0, es});
        check({tag, ".outs"}, {17'd0, w_outs}, {17'd0, ev});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
        op    = o;
        funct = f;
        zero  = z;
    endtask

    // Funct decode vectors for R-type EXECUTE
    logic [5:0] fn_tab  [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    logic [2:0] alc_tab [6] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111,    3'b010};

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        set_instr(6'b111111, 6'b000000, 1'b1);
        #12;
        // Reset held: FETCH values, zero=1 must not matter
        check("reset.state", {28'd0, state}, 32'd0);
        check("reset.outs", {17'd0, w_outs}, {17'd0, V_FETCH});
        @(negedge clk);
        reset = 1'b0;

        // lw with zero=1 throughout: zero must not leak into pcen
        set_instr(6'b100011, 6'b000000, 1'b1);
        step("lw.fetch",  4'd0, V_FETCH);
        step("lw.decode", 4'd1, V_DECODE);
        step("lw.memadr", 4'd2, V_MEMADR);
        step("lw.memrd",  4'd3, V_MEMRD);
        step("lw.memwb",  4'd4, V_MEMWB);

        // sw
        set_instr(6'b101011, 6'b000000, 1'b0);
        step("sw.fetch",  4'd0, V_FETCH);
        step("sw.decode", 4'd1, V_DECODE);
        step("sw.memadr", 4'd2, V_MEMADR);
        step("sw.memwr",  4'd5, V_MEMWR);

        // R-type over all funct codes including an unknown one
        for (int i = 0; i < 6; i++) begin
            set_instr(6'b000000, fn_tab[i], 1'b1);
            step("r.fetch",  4'd0, V_FETCH);
            step("r.decode", 4'd1, V_DECODE);
            step($sformatf("r.exec%0d", i), 4'd6, v_exec(alc_tab[i]));
            step("r.aluwb",  4'd7, V_ALUWB);
        end

        // beq taken / not taken
        set_instr(6'b000100, 6'b000000, 1'b1);
        step("beqt.fetch",  4'd0, V_FETCH);
        step("beqt.decode", 4'd1, V_DECODE);
        step("beqt.branch", 4'd8, V_BEQ_T);
        set_instr(6'b000100, 6'b000000, 1'b0);
        step("beqn.fetch",  4'd0, V_FETCH);
        step("beqn.decode", 4'd1, V_DECODE);
        step("beqn.branch", 4'd8, V_BEQ_N);

        // addi
        set_instr(6'b001000, 6'b000000, 1'b1);
        step("addi.fetch",  4'd0, V_FETCH);
        step("addi.decode", 4'd1, V_DECODE);
        step("addi.exec",   4'd9, V_MEMADR);
        step("addi.wb",     4'd10, V_ADDIWB);

        // j
        set_instr(6'b000010, 6'b000000, 1'b0);
        step("j.fetch",  4'd0, V_FETCH);
        step("j.decode", 4'd1, V_DECODE);
        step("j.jump",   4'd11, V_JUMP);

        // illegal opcode: two cycles, no strobes in DECODE
        set_instr(6'b111111, 6'b000000, 1'b1);
        step("ill.fetch",  4'd0, V_FETCH);
        step("ill.decode", 4'd1, V_DECODE);

        // Abandon lw in MEMRD with an asynchronous reset pulse
        set_instr(6'b100011, 6'b000000, 1'b0);
        step("rst.fetch",  4'd0, V_FETCH);
        step("rst.decode", 4'd1, V_DECODE);
        step("rst.memadr", 4'd2, V_MEMADR);
        check("rst.memrd", {28'd0, state}, 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("rst.async.state", {28'd0, state}, 32'd0);
        check("rst.async.outs", {17'd0, w_outs}, {17'd0, V_FETCH});
        @(negedge clk);
        reset = 1'b0;
        step("rst.after.fetch",  4'd0, V_FETCH);
        step("rst.after.decode", 4'd1, V_DECODE);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_multicycle_control
`default_nettype wire
